serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
Sequencer that time-multiplexes one 1-bit full adder (the existing rtl_adder) to perform N-bit ripple additions bit-serially, LSB first.
- Accepts operands over a valid/ready handshake.
- Drives the adder's a/b/ci inputs one bit per cycle and collects sum/co.
- Returns the N-bit sum plus carry-out over a second valid/ready handshake.
- Sits between a requesting controller and a standalone rtl_adder instance in the integrating wrapper.

Parameters:
N, 8, operand width in bits; legal range 1 to 64.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
in_a  input  N  operand A
in_b  input  N  operand B
in_ci  input  1  carry-in
fa_a  output  1  to adder input a
fa_b  output  1  to adder input b
fa_ci  output  1  to adder input ci
fa_sum  input  1  from adder sum (combinational from fa_*)
fa_co  input  1  from adder co
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  N  N-bit sum
out_co  output  1  final carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: single clock domain. rst sampled on the clk rising edge, overrides everything.
- Reset values: state=IDLE, all shift registers/counter/carry = 0, in_ready=1, out_valid=0, out_sum=0, out_co=0, fa_a=fa_b=fa_ci=0, busy=0.
- States: IDLE, RUN, DONE (enum in package).
- IDLE:
  - in_ready=1; fa_* = 0.
  - On in_valid && in_ready: load a_sr=in_a, b_sr=in_b, carry_q=in_ci, cnt=0, sum_sr=0; go to RUN.
- RUN:
  - in_ready=0; fa_a=a_sr[0], fa_b=b_sr[0], fa_ci=carry_q (registered sources, no combinational path from in_*).
  - Each edge: sum_sr <= {fa_sum, sum_sr[N-1:1]}, carry_q <= fa_co, a_sr/b_sr shift right by 1, cnt <= cnt+1.
  - When cnt==N-1 at the edge, go to DONE.
  - For N=1: exactly one RUN cycle.
- DONE:
  - out_valid=1, out_sum=sum_sr, out_co=carry_q, fa_* = 0, in_ready=0.
  - Result held stable while out_ready=0 (unbounded backpressure).
  - On out_valid && out_ready: go to IDLE; out_valid drops next cycle.
- Latency: operand accept edge → out_valid high after exactly N further edges.
  - Minimum initiation interval N+2 cycles (IDLE accept, N RUN, DONE handshake).
  - No accept in the same cycle as the DONE handshake.
- in_valid outside IDLE is ignored; in_a/in_b/in_ci need only be stable in the accept cycle.
- Arithmetic: {out_co, out_sum} == in_a + in_b + in_ci, modulo 2^(N+1); no overflow flag.
- Counter width: max(1, $clog2(N)); cnt never wraps beyond N-1.
- Reset mid-operation (RUN or DONE):
  - Abort; return to IDLE with reset values.
  - No out_valid is produced for the aborted operation.
  - A partially computed result is never presented.
- Output registering: out_valid/out_sum/out_co come from registers; fa_* are state-qualified decode of registers only.

Decomposition:
- Package serial_add_pkg: state_t enum (IDLE, RUN, DONE) and a cnt_width(N) function returning max(1, $clog2(N)).
- No sub-module inside the block.
- The integrating wrapper serial_add_top instantiates serial_add_seq and rtl_adder, connecting fa_a/fa_b/fa_ci/fa_sum/fa_co to a/b/ci/sum/co.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, out_sum=0, out_co=0, fa_*=0, busy=0, in_ready=1 after release; no accept occurs during reset.
2. N=8, a=8'h5A, b=8'h33, ci=0 → out_valid exactly 8 edges after accept, out_sum=8'h8D, out_co=0; fa_a trace LSB-first 0,1,0,1,1,0,1,0.
3. Carry extremes: a=8'hFF, b=8'h01, ci=0 → sum 8'h00, co 1; a=8'hFF, b=8'hFF, ci=1 → sum 8'hFF, co 1; a=0, b=0, ci=1 → sum 8'h01, co 0.
4. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and changing in_a → out_sum/out_co/out_valid stable, in_ready=0, no new accept; out_ready=1 → IDLE next cycle.
5. Reset mid-RUN after 3 bit cycles of a=8'hF0, b=8'h0F → IDLE, no out_valid; next op a=8'h10, b=8'h20, ci=0 → sum 8'h30, co 0.
6. Back-to-back with in_valid and out_ready held high, N=1 and N=8 builds → initiation interval exactly N+2 cycles; results match the reference model a+b+ci for 1000 random operand sets.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

    // Sequencer phases: waiting for operands, shifting bits through the
    // adder, holding the result for the consumer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: enough to count 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_add_seq.sv
// Bit-serial N-bit adder sequencer. Time-multiplexes one external 1-bit
// full adder, feeding it one operand bit per cycle (LSB first) and
// collecting sum/carry back, with valid/ready handshakes on both sides.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_ci,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_ci,
    input  logic         fa_sum,
    input  logic         fa_co,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_co,
    output logic         busy
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    logic [N-1:0]  r_a_sr;
    logic [N-1:0]  r_b_sr;
    logic [N-1:0]  r_sum_sr;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic          r_out_valid;
    logic [N-1:0]  r_out_sum;
    logic          r_out_co;

    logic          w_run;
    logic [N-1:0]  w_sum_next;

    assign w_run = (r_state == RUN);

    // Shift the adder's sum bit in at the MSB end. Concatenating then
    // shifting keeps this legal for N=1, where the result is just fa_sum.
    assign w_sum_next = N'({fa_sum, r_sum_sr} >> 1);

    // Adder inputs are gated by state so the adder sees zeros outside RUN;
    // all sources are registers, so nothing flows through from in_*.
    assign fa_a  = w_run & r_a_sr[0];
    assign fa_b  = w_run & r_b_sr[0];
    assign fa_ci = w_run & r_carry;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_co    = r_out_co;

    // Sequencer FSM plus its datapath registers and registered outputs.
    // NOTE: every register here is assigned with <= so all of them sample
    // the pre-edge values; a blocking = would let later lines see updated
    // state within the same edge and break the shift/carry chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_co    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr   <= in_a;
                        r_b_sr   <= in_b;
                        r_carry  <= in_ci;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_sum_sr <= w_sum_next;
                    r_carry  <= fa_co;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    if (r_cnt == LAST) begin
                        // Final bit: publish the complete result in one step,
                        // so a partial sum never appears on the outputs.
                        r_out_sum   <= w_sum_next;
                        r_out_co    <= fa_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: an N=8 and an N=1 instance, each
// wired to a behavioural full adder, checked against a queue-based model of
// "result = a + b + ci" plus directed literal expectations.
module tb_serial_add_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- N=8 instance ----------------
    logic       in_valid8, in_ready8, in_ci8;
    logic [7:0] in_a8, in_b8;
    logic       fa_a8, fa_b8, fa_ci8, fa_sum8, fa_co8;
    logic       out_valid8, out_ready8, out_co8, busy8;
    logic [7:0] out_sum8;

    assign {fa_co8, fa_sum8} = 2'(fa_a8) + 2'(fa_b8) + 2'(fa_ci8);

    serial_add_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_ci(in_ci8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_ci(fa_ci8),
        .fa_sum(fa_sum8), .fa_co(fa_co8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_sum(out_sum8), .out_co(out_co8), .busy(busy8)
    );

    // ---------------- N=1 instance ----------------
    logic       in_valid1, in_ready1, in_ci1;
    logic [0:0] in_a1, in_b1;
    logic       fa_a1, fa_b1, fa_ci1, fa_sum1, fa_co1;
    logic       out_valid1, out_ready1, out_co1, busy1;
    logic [0:0] out_sum1;

    assign {fa_co1, fa_sum1} = 2'(fa_a1) + 2'(fa_b1) + 2'(fa_ci1);

    serial_add_seq #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_ci(in_ci1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_ci(fa_ci1),
        .fa_sum(fa_sum1), .fa_co(fa_co1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_co(out_co1), .busy(busy1)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic stream = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model, N=8 ----------------
    logic [8:0] q8[$];
    int   acc8 = 0;
    int   n_acc8 = 0;
    logic prev_ov8 = 1'b0;
    logic have_last8 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            prev_ov8   <= 1'b0;
            have_last8 <= 1'b0;
        end else begin
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    check("unexpected_out_valid8", out_valid8, 0);
                end else begin
                    check("model_sum8", out_sum8, q8[0][7:0]);
                    check("model_co8", out_co8, q8[0][8]);
                    if (!prev_ov8) check("latency8", cyc - acc8, 8);
                    if (out_ready8) void'(q8.pop_front());
                end
            end
            prev_ov8 <= out_valid8;
            if (in_valid8 && in_ready8) begin
                q8.push_back(9'(in_a8) + 9'(in_b8) + 9'(in_ci8));
                acc8 <= cyc + 1;
                if (stream) begin
                    if (have_last8) check("ii8", cyc + 1 - acc8, 10);
                    have_last8 <= 1'b1;
                    n_acc8     <= n_acc8 + 1;
                end
            end
        end
    end

    // ---------------- reference model, N=1 ----------------
    logic [1:0] q1[$];
    int   acc1 = 0;
    int   n_acc1 = 0;
    logic prev_ov1 = 1'b0;
    logic have_last1 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            prev_ov1   <= 1'b0;
            have_last1 <= 1'b0;
        end else begin
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    check("unexpected_out_valid1", out_valid1, 0);
                end else begin
                    check("model_sum1", out_sum1, q1[0][0]);
                    check("model_co1", out_co1, q1[0][1]);
                    if (!prev_ov1) check("latency1", cyc - acc1, 1);
                    if (out_ready1) void'(q1.pop_front());
                end
            end
            prev_ov1 <= out_valid1;
            if (in_valid1 && in_ready1) begin
                q1.push_back(2'(in_a1) + 2'(in_b1) + 2'(in_ci1));
                acc1 <= cyc + 1;
                if (stream) begin
                    if (have_last1) check("ii1", cyc + 1 - acc1, 3);
                    have_last1 <= 1'b1;
                    n_acc1     <= n_acc1 + 1;
                end
            end
        end
    end

    // ---------------- directed driver helper (N=8) ----------------
    // Called #1 after a rising edge; returns at the falling edge where
    // out_valid is first seen, with the fa_a bit trace of the RUN phase.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         output logic [7:0] sum, output logic co, output logic [7:0] trace);
        int nb;
        in_valid8 = 1'b1;
        in_a8 = a;
        in_b8 = b;
        in_ci8 = ci;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready8) break;
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_a8 = 8'($urandom);
        in_b8 = 8'($urandom);
        trace = '0;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid8) break;
            if (nb < 8) trace[nb] = fa_a8;
            nb++;
        end
        if (!out_valid8) check("op_timeout", out_valid8, 1);
        sum = out_sum8;
        co  = out_co8;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] sum;
        logic       co;
    } vec_t;

    vec_t       vecs[3];
    logic [7:0] s, tr;
    logic       c;
    logic       ov_seen;

    initial begin
        // ---- 1: reset with in_valid held high ----
        rst = 1'b1;
        in_valid8 = 1'b1; in_a8 = 8'hAA; in_b8 = 8'h55; in_ci8 = 1'b1; out_ready8 = 1'b1;
        in_valid1 = 1'b1; in_a1 = 1'b1;  in_b1 = 1'b1;  in_ci1 = 1'b1; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_valid1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid8, 0);
        check("rst_out_sum", out_sum8, 8'h00);
        check("rst_out_co", out_co8, 0);
        check("rst_fa", {fa_a8, fa_b8, fa_ci8}, 3'b000);
        check("rst_busy", busy8, 0);
        check("rst_in_ready", in_ready8, 1);
        check("rst_busy_n1", busy1, 0);
        @(posedge clk);
        #1;

        // ---- 2: 5A + 33 + 0, fa_a bit trace LSB first 0,1,0,1,1,0,1,0 ----
        do_op(8'h5A, 8'h33, 1'b0, s, c, tr);
        check("t2_sum", s, 8'h8D);
        check("t2_co", c, 0);
        check("t2_fa_a_trace", tr, 8'b0101_1010);
        @(posedge clk);
        #1;

        // ---- 3: carry extremes ----
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, s, c, tr);
            check($sformatf("t3_sum_%0d", i), s, vecs[i].sum);
            check($sformatf("t3_co_%0d", i), c, vecs[i].co);
            @(posedge clk);
            #1;
        end

        // ---- 4: backpressure in DONE with in_valid high ----
        out_ready8 = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, s, c, tr);
        check("t4_sum", s, 8'h46);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid8 = 1'b1;
            in_a8 = 8'(i * 37 + 1);
            @(negedge clk);
            check("t4_hold_valid", out_valid8, 1);
            check("t4_hold_sum", out_sum8, 8'h46);
            check("t4_hold_co", out_co8, 0);
            check("t4_in_ready", in_ready8, 0);
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_released_valid", out_valid8, 0);
        check("t4_released_idle", in_ready8, 1);
        @(posedge clk);
        #1;

        // ---- 5: reset after 3 bit cycles of F0 + 0F ----
        in_valid8 = 1'b1; in_a8 = 8'hF0; in_b8 = 8'h0F; in_ci8 = 1'b0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_abort_busy", busy8, 0);
        check("t5_abort_in_ready", in_ready8, 1);
        ov_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ov_seen = ov_seen | out_valid8;
        end
        check("t5_no_out_valid", ov_seen, 0);
        @(posedge clk);
        #1;
        do_op(8'h10, 8'h20, 1'b0, s, c, tr);
        check("t5_sum", s, 8'h30);
        check("t5_co", c, 0);
        @(posedge clk);
        #1;

        // ---- 6: back-to-back random streams on both instances ----
        stream = 1'b1;
        for (int k = 0; k < 20000 && (n_acc8 < 1000 || n_acc1 < 1000); k++) begin
            in_valid8 = (n_acc8 < 1000);
            in_a8 = 8'($urandom); in_b8 = 8'($urandom); in_ci8 = 1'($urandom);
            in_valid1 = (n_acc1 < 1000);
            in_a1 = 1'($urandom); in_b1 = 1'($urandom); in_ci1 = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid8 = 1'b0;
        in_valid1 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        stream = 1'b0;
        check("t6_accepts8", n_acc8, 1000);
        check("t6_accepts1", n_acc1, 1000);
        check("t6_drained8", q8.size(), 0);
        check("t6_drained1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
